cam_capture: RTL

//  Receiving end of the OV7670 parallel pixel interface (RGB565, two bytes per pixel, href/vsync framing).

---
 rtl/cam_capture.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/cam_capture.sv
// cam_capture: OV7670 RGB565 parallel capture into an RGB332 framebuffer.
// Camera pins are oversampled in the clk domain; pclk is treated as data.
module cam_capture #(
  parameter int IMG_W = 320,
  parameter int IMG_H = 240,
  parameter int AW    = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cap_en,
  input  logic          CAM_pclk,
  input  logic          CAM_vsync,
  input  logic          CAM_href,
  input  logic [7:0]    CAM_px_data,
  output logic [AW-1:0] px_addr,
  output logic [7:0]    px_data,
  output logic          px_wr,
  output logic          frame_done,
  output logic          frame_err
);

  localparam int CW = $clog2(IMG_W + 1) + 1;
  localparam int RW = $clog2(IMG_H + 1) + 1;
  localparam logic [AW-1:0] LAST = AW'(IMG_W * IMG_H - 1);
  localparam logic [CW-1:0] COL_MAX = '1;
  localparam logic [RW-1:0] ROW_MAX = '1;

  typedef enum logic {WAIT_FRAME, CAPTURE} state_t;

  state_t        state_q, state_d;
  logic [1:0]    pclk_s_q, vs_s_q, hr_s_q;
  logic [7:0]    d_s0_q, d_s1_q;
  logic          pclk_p_q, vs_p_q, hr_p_q;
  logic [AW-1:0] addr_q, addr_d;
  logic          full_q, full_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          err_q, err_d;
  logic          bsel_q, bsel_d;
  logic [7:0]    b1_q, b1_d;
  logic [7:0]    pdat_q, pdat_d;
  logic          wr_q, wr_d;
  logic          done_q, done_d;
  logic          ferr_q, ferr_d;

  logic pclk_rise, vs_rise, vs_fall, hr_fall;

  assign pclk_rise = pclk_s_q[1] & ~pclk_p_q;
  assign vs_rise   = vs_s_q[1] & ~vs_p_q;
  assign vs_fall   = ~vs_s_q[1] & vs_p_q;
  assign hr_fall   = ~hr_s_q[1] & hr_p_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pclk_s_q <= '0;
      vs_s_q   <= '0;
      hr_s_q   <= '0;
      d_s0_q   <= '0;
      d_s1_q   <= '0;
      pclk_p_q <= 1'b0;
      vs_p_q   <= 1'b0;
      hr_p_q   <= 1'b0;
      state_q  <= WAIT_FRAME;
      addr_q   <= '0;
      full_q   <= 1'b0;
      col_q    <= '0;
      row_q    <= '0;
      err_q    <= 1'b0;
      bsel_q   <= 1'b0;
      b1_q     <= '0;
      pdat_q   <= '0;
      wr_q     <= 1'b0;
      done_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      pclk_s_q <= {pclk_s_q[0], CAM_pclk};
      vs_s_q   <= {vs_s_q[0], CAM_vsync};
      hr_s_q   <= {hr_s_q[0], CAM_href};
      d_s0_q   <= CAM_px_data;
      d_s1_q   <= d_s0_q;
      pclk_p_q <= pclk_s_q[1];
      vs_p_q   <= vs_s_q[1];
      hr_p_q   <= hr_s_q[1];
      state_q  <= state_d;
      addr_q   <= addr_d;
      full_q   <= full_d;
      col_q    <= col_d;
      row_q    <= row_d;
      err_q    <= err_d;
      bsel_q   <= bsel_d;
      b1_q     <= b1_d;
      pdat_q   <= pdat_d;
      wr_q     <= wr_d;
      done_q   <= done_d;
      ferr_q   <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    full_d  = full_q;
    col_d   = col_q;
    row_d   = row_q;
    err_d   = err_q;
    bsel_d  = bsel_q;
    b1_d    = b1_q;
    pdat_d  = pdat_q;
    wr_d    = 1'b0;
    done_d  = 1'b0;
    ferr_d  = ferr_q;

    // Post-strobe advance; the last address latches "full" instead of wrapping.
    if (wr_q) begin
      if (addr_q == LAST) full_d = 1'b1;
      else                addr_d = addr_q + 1'b1;
      if (col_q != COL_MAX) col_d = col_q + 1'b1;
    end

    unique case (state_q)
      WAIT_FRAME: begin
        if (vs_fall && cap_en) begin
          state_d = CAPTURE;
          addr_d  = '0;
          full_d  = 1'b0;
          col_d   = '0;
          row_d   = '0;
          err_d   = 1'b0;
          bsel_d  = 1'b0;
        end
      end
      CAPTURE: begin
        if (pclk_rise && hr_s_q[1]) begin
          if (!bsel_q) begin
            b1_d   = d_s1_q;
            bsel_d = 1'b1;
          end else begin
            bsel_d = 1'b0;
            if (full_d) begin
              err_d = 1'b1;
            end else begin
              pdat_d = {b1_q[7:5], b1_q[2:0], d_s1_q[4:3]};
              wr_d   = 1'b1;
            end
          end
        end
        // Line end uses col_d so a strobe in this same clk is counted.
        if (hr_fall) begin
          if (bsel_q) err_d = 1'b1;
          if (col_d != CW'(IMG_W)) err_d = 1'b1;
          bsel_d = 1'b0;
          col_d  = '0;
          if (row_q != ROW_MAX) row_d = row_q + 1'b1;
        end
        if (vs_rise) begin
          state_d = WAIT_FRAME;
          done_d  = 1'b1;
          ferr_d  = err_d | (row_d != RW'(IMG_H));
        end
      end
      default: state_d = WAIT_FRAME;
    endcase
  end

  assign px_addr    = addr_q;
  assign px_data    = pdat_q;
  assign px_wr      = wr_q;
  assign frame_done = done_q;
  assign frame_err  = ferr_q;

endmodule
